// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared raster-timing constants and the per-pixel timing bundle used by
//   video_sig_gen and the downstream pixel pipeline.
//   - 1280x720p60 defaults (74.25 MHz pixel clock) and derived totals / sync
//     window bounds, all as 32-bit localparams.
//   - Counter widths for hcount / vcount / frame counter.
//   - video_timing_t: {hcount, vcount, hs, vs, ad, nf} for one raster position.
package video_timing_pkg;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;
    localparam int FPS_720P      = 60;

    localparam int H_TOTAL_720P      = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;
    localparam int V_TOTAL_720P      = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;
    localparam int H_SYNC_START_720P = H_ACTIVE_720P + H_FP_720P;
    localparam int H_SYNC_END_720P   = H_SYNC_START_720P + H_SYNC_720P - 1;
    localparam int V_SYNC_START_720P = V_ACTIVE_720P + V_FP_720P;
    localparam int V_SYNC_END_720P   = V_SYNC_START_720P + V_SYNC_720P - 1;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int FCOUNT_W = 6;

    typedef struct packed {
        logic [HCOUNT_W-1:0] hcount;
        logic [VCOUNT_W-1:0] vcount;
        logic                hs;
        logic                vs;
        logic                ad;
        logic                nf;
    } video_timing_t;

endpackage

// File: rtl/video_sig_gen.sv
// video_sig_gen
//   Free-running raster timing generator feeding the TMDS encoders.
//   The next raster position is computed combinationally, every flag is
//   decoded from that next position, and the whole bundle is registered, so
//   outputs carry no combinational path and each flag lines up with the
//   hcount/vcount it describes.
// Ports:
//   clk_in      pixel clock
//   rst_n_in    asynchronous active-low reset
//   hcount_out  horizontal position 0..H_TOTAL-1
//   vcount_out  vertical position 0..V_TOTAL-1
//   hs_out      horizontal sync, active-high
//   vs_out      vertical sync, active-high (whole lines)
//   ad_out      active-draw flag
//   nf_out      one-cycle strobe at (H_ACTIVE, V_ACTIVE)
//   fc_out      frame counter 0..FPS-1, steps together with nf_out
module video_sig_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int H_FP     = H_FP_720P,
    parameter int H_SYNC   = H_SYNC_720P,
    parameter int H_BP     = H_BP_720P,
    parameter int V_ACTIVE = V_ACTIVE_720P,
    parameter int V_FP     = V_FP_720P,
    parameter int V_SYNC   = V_SYNC_720P,
    parameter int V_BP     = V_BP_720P,
    parameter int FPS      = FPS_720P
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                hs_out,
    output logic                vs_out,
    output logic                ad_out,
    output logic                nf_out,
    output logic [FCOUNT_W-1:0] fc_out
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    generate
        if (H_TOTAL > (1 << HCOUNT_W)) begin : g_h_too_big
            $error("video_sig_gen: H_TOTAL exceeds hcount width");
        end
        if (V_TOTAL > (1 << VCOUNT_W)) begin : g_v_too_big
            $error("video_sig_gen: V_TOTAL exceeds vcount width");
        end
        if (FPS < 1 || FPS > (1 << FCOUNT_W)) begin : g_fps_bad
            $error("video_sig_gen: FPS out of frame-counter range");
        end
    endgenerate

    // Counter-width copies so every decode compares at counter width.
    localparam logic [HCOUNT_W-1:0] H_LAST   = HCOUNT_W'(H_TOTAL - 1);
    localparam logic [VCOUNT_W-1:0] V_LAST   = VCOUNT_W'(V_TOTAL - 1);
    localparam logic [HCOUNT_W-1:0] H_ACT_C  = HCOUNT_W'(H_ACTIVE);
    localparam logic [VCOUNT_W-1:0] V_ACT_C  = VCOUNT_W'(V_ACTIVE);
    localparam logic [HCOUNT_W-1:0] HS_LO    = HCOUNT_W'(HS_START);
    localparam logic [HCOUNT_W-1:0] HS_HI    = HCOUNT_W'(HS_END);
    localparam logic [VCOUNT_W-1:0] VS_LO    = VCOUNT_W'(VS_START);
    localparam logic [VCOUNT_W-1:0] VS_HI    = VCOUNT_W'(VS_END);
    localparam logic [FCOUNT_W-1:0] FC_LAST  = FCOUNT_W'(FPS - 1);

    video_timing_t       cur, nxt;
    logic [FCOUNT_W-1:0] fc_q, fc_nxt;

    always_comb begin
        nxt = '0;
        nxt.hcount = (cur.hcount == H_LAST) ? '0 : cur.hcount + 1'b1;
        nxt.vcount = cur.vcount;
        if (cur.hcount == H_LAST)
            nxt.vcount = (cur.vcount == V_LAST) ? '0 : cur.vcount + 1'b1;

        nxt.hs = (nxt.hcount >= HS_LO) && (nxt.hcount <= HS_HI);
        nxt.vs = (nxt.vcount >= VS_LO) && (nxt.vcount <= VS_HI);
        nxt.ad = (nxt.hcount < H_ACT_C) && (nxt.vcount < V_ACT_C);
        nxt.nf = (nxt.hcount == H_ACT_C) && (nxt.vcount == V_ACT_C);

        fc_nxt = fc_q;
        if (nxt.nf)
            fc_nxt = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
    end

    // Reset parks on the last raster position so the first edge after
    // release lands on (0,0) and the first visible pixel is not lost.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cur.hcount <= H_LAST;
            cur.vcount <= V_LAST;
            cur.hs     <= 1'b0;
            cur.vs     <= 1'b0;
            cur.ad     <= 1'b0;
            cur.nf     <= 1'b0;
            fc_q       <= '0;
        end else begin
            cur  <= nxt;
            fc_q <= fc_nxt;
        end
    end

    assign hcount_out = cur.hcount;
    assign vcount_out = cur.vcount;
    assign hs_out     = cur.hs;
    assign vs_out     = cur.vs;
    assign ad_out     = cur.ad;
    assign nf_out     = cur.nf;
    assign fc_out     = fc_q;

endmodule

// File: tb/tb_video_sig_gen.sv
// Testbench for video_sig_gen: a 720p instance (reset state, first lines)
// and a tiny-raster instance (many full frames, frame-counter wrap,
// asynchronous mid-frame reset), both checked cycle by cycle against a
// closed-form raster model through a scoreboard queue.
module tb_video_sig_gen;

    localparam int SHA = 8, SHF = 2, SHS = 2, SHB = 2;
    localparam int SVA = 4, SVF = 1, SVS = 1, SVB = 1;
    localparam int SFPS = 3;
    localparam int NCYC = 3400;

    localparam logic [30:0] RST_A = {11'd1649, 10'd749, 4'b0000, 6'd0};
    localparam logic [30:0] RST_B = {11'd13, 10'd6, 4'b0000, 6'd0};

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] hc_a, hc_b;
    logic [9:0]  vc_a, vc_b;
    logic        hs_a, vs_a, ad_a, nf_a, hs_b, vs_b, ad_b, nf_b;
    logic [5:0]  fc_a, fc_b;

    video_sig_gen dut_a (
        .clk_in(clk), .rst_n_in(rst_a_n),
        .hcount_out(hc_a), .vcount_out(vc_a),
        .hs_out(hs_a), .vs_out(vs_a), .ad_out(ad_a), .nf_out(nf_a), .fc_out(fc_a)
    );

    video_sig_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .FPS(SFPS)
    ) dut_b (
        .clk_in(clk), .rst_n_in(rst_b_n),
        .hcount_out(hc_b), .vcount_out(vc_b),
        .hs_out(hs_b), .vs_out(vs_b), .ad_out(ad_b), .nf_out(nf_b), .fc_out(fc_b)
    );

    wire [30:0] obs_a = {hc_a, vc_a, hs_a, vs_a, ad_a, nf_a, fc_a};
    wire [30:0] obs_b = {hc_b, vc_b, hs_b, vs_b, ad_b, nf_b, fc_b};

    int nchk = 0;
    int nfail = 0;
    logic [30:0] qa[$];
    logic [30:0] qb[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Position p = edges since release minus one.
    function automatic logic [30:0] model(input int p, input int ha, input int hf,
                                          input int hsw, input int hb, input int va,
                                          input int vf, input int vsw, input int vb,
                                          input int fps);
        int ht, vt, ft, h, v, off, nfr;
        logic hs, vs, ad, nf;
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        ft  = ht * vt;
        h   = p % ht;
        v   = (p / ht) % vt;
        hs  = (h >= ha + hf) && (h < ha + hf + hsw);
        vs  = (v >= va + vf) && (v < va + vf + vsw);
        ad  = (h < ha) && (v < va);
        nf  = (h == ha) && (v == va);
        off = va * ht + ha;
        nfr = (p >= off) ? ((p - off) / ft + 1) : 0;
        return {11'(h), 10'(v), hs, vs, ad, nf, 6'(nfr % fps)};
    endfunction

    function automatic logic [30:0] model_a(input int p);
        return model(p, 1280, 110, 40, 220, 720, 5, 5, 20, 60);
    endfunction

    function automatic logic [30:0] model_b(input int p);
        return model(p, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SFPS);
    endfunction

    // Monitor: pop expected values on the falling edge, away from the
    // active edge, and gather hsync statistics on the 720p instance.
    int   hs_cnt = 0;
    int   hs_first = -1;
    int   hs_last = -1;
    logic [30:0] ea, eb;
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("a_cycle", {1'b0, obs_a}, {1'b0, ea});
            if (rst_a_n && hs_a && vc_a == 10'd0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(hc_a);
                hs_last = int'(hc_a);
            end
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("b_cycle", {1'b0, obs_b}, {1'b0, eb});
        end
    end

    initial begin
        int  kb;
        bit  b_rst;
        // Reset held 20 cycles.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            qa.push_back(RST_A);
            qb.push_back(RST_B);
        end
        @(negedge clk);
        #1;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        kb = 0;
        b_rst = 1'b0;

        for (int k = 1; k <= NCYC; k++) begin
            @(posedge clk);
            qa.push_back(model_a(k - 1));
            if (k == 340) begin
                // Asynchronous reset between edges, mid-frame on dut_b.
                #1;
                chk("b_pre_rst", {1'b0, obs_b}, {1'b0, model_b(kb)});
                kb++;
                #1;
                rst_b_n = 1'b0;
                #1;
                chk("b_async_rst", {1'b0, obs_b}, {1'b0, RST_B});
                b_rst = 1'b1;
            end else if (b_rst) begin
                qb.push_back(RST_B);
                if (k == 346) begin
                    #2;
                    rst_b_n = 1'b1;
                    b_rst = 1'b0;
                    kb = 0;
                end
            end else begin
                qb.push_back(model_b(kb));
                kb++;
            end
        end

        @(negedge clk);
        #1;
        chk("hs_len_line0", hs_cnt, 40);
        chk("hs_first_h", hs_first, 1390);
        chk("hs_last_h", hs_last, 1429);
        chk("queues_drained", qa.size() + qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/video_sig_gen.md
# video_sig_gen

Free-running raster timing generator for the HDMI output path. It produces the pixel coordinates, sync pulses, active-draw flag and frame strobes that the pixel pipeline and the three per-channel TMDS encoders consume. It sits directly upstream of the encoders:
- `ad_out` drives the encoders' video-enable input.
- `{vs_out, hs_out}` drive the blue channel's control input.
- Default timing is 1280x720p60 on a 74.25 MHz pixel clock.

## Interface
Parameters:
- `H_ACTIVE`, default 1280: visible pixels per line.
- `H_FP`, default 110: horizontal front porch, in pixels.
- `H_SYNC`, default 40: horizontal sync width.
- `H_BP`, default 220: horizontal back porch. H_TOTAL = 1650.
- `V_ACTIVE`, default 720: visible lines.
- `V_FP`, default 5: vertical front porch, in lines.
- `V_SYNC`, default 5: vertical sync width.
- `V_BP`, default 20: vertical back porch. V_TOTAL = 750.
- `FPS`, default 60: frame counter modulus.

Ports:
- `clk_in`  in  1  pixel clock.
- `rst_n_in`  in  1  reset; one clock, asynchronous, active-low.
- `hcount_out`  out  11  horizontal position, 0..H_TOTAL-1.
- `vcount_out`  out  10  vertical position, 0..V_TOTAL-1.
- `hs_out`  out  1  horizontal sync, active-high.
- `vs_out`  out  1  vertical sync, active-high.
- `ad_out`  out  1  active draw: high when hcount < H_ACTIVE and vcount < V_ACTIVE.
- `nf_out`  out  1  new-frame strobe, one cycle wide.
- `fc_out`  out  6  frame counter, 0..FPS-1.

## Operation
- Two counters, h and v. h increments every clock. At H_TOTAL-1 it wraps to 0, and v increments on that same edge. v wraps from V_TOTAL-1 to 0 when h wraps.
- `hs_out` is high for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 1390..1429.
- `vs_out` is high for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 725..729, across the whole line. It is not offset within the line.
- `nf_out` is high only at (hcount,vcount) = (H_ACTIVE, V_ACTIVE), i.e. (1280,720). This is the first blanking pixel after the last visible line.
- `fc_out` increments on the same edge that asserts `nf_out` and is visible together with it. It wraps FPS-1 → 0.
- All outputs are registered. Flags are decoded from the next counter values, so every flag is cycle-aligned with the `hcount_out`/`vcount_out` it describes. There are no combinational paths to outputs.
- Width rules:
  - Comparisons are done at counter width; parameter sums are evaluated as 32-bit localparams.
  - Elaboration fails if H_TOTAL > 2048 or V_TOTAL > 1024.

## Timing
- Reset (asserted, async):
  - hcount_out = H_TOTAL-1 (1649), vcount_out = V_TOTAL-1 (749).
  - hs_out = vs_out = ad_out = nf_out = 0, fc_out = 0.
  - This state is consistent with the decode: (1649,749) is back-porch blanking.
- First rising edge after release: (0,0) with ad_out = 1. The first visible pixel is not lost.
- Latency: outputs at edge n describe raster position n (modulo frame). The encoder adds its own register stage. Downstream pixel data must be aligned to `ad_out` by the consumer.
- Line boundary: (1649,v) → (0,v+1) in one edge. Frame boundary: (1649,749) → (0,0).
- Reset asserted mid-frame: all outputs go to reset values immediately, with no wait for a clock edge. Timing restarts from (0,0) one edge after release.
- `nf_out` is never asserted during reset or on the first edge after release.

## Structure
- Package `video_timing_pkg` holds:
  - localparams for the 720p constants;
  - derived H_TOTAL / V_TOTAL / sync start and end;
  - a `video_timing_t` struct {hcount, vcount, hs, vs, ad, nf}, shared with the pixel pipeline.
- No sub-module needed: two counters plus decode, in a single always_ff with the async active-low reset.

## Test plan
- Reset held 20 cycles, released → values during reset are (1649,749), flags 0, fc 0. First edge gives (0,0) with ad=1. Edge 1280 gives hcount=1280 with ad=0.
- Run one line → hs_out high for exactly 40 cycles, first at hcount=1390, last at 1429. At (1649,0) → (0,1), vcount increments by exactly 1.
- Run one full frame (1,237,500 cycles) → vs_out high for 5×1650 = 8250 cycles covering vcount 725..729. ad_out high for 921,600 cycles. nf_out is a single pulse at (1280,720), and fc_out goes 0→1 on that cycle.
- Run 60 frames → fc_out reaches 59, then wraps to 0 on the 60th nf_out. Period between nf_out pulses is exactly 1,237,500 cycles.
- Assert rst_n_in low asynchronously at (600,300), between clock edges → outputs reach reset values before the next edge. After release the first frame is full length, with nf_out 1,237,500−... i.e. at cycle 1280+720×1650 after release.
- Small parameter set (H 8/2/2/2, V 4/1/1/1) → exhaustive per-cycle compare against a reference model over 3 frames.
